usb_in_stream_arbiter: RTL



---
 rtl/usb_in_stream_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/usb_in_stream_arbiter.sv
// Round-robin, packet-locked arbiter sharing the CDC IN byte channel between
// NUM_REQ byte-stream requesters. One registered output slot drives in_*.
module usb_in_stream_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int MAX_BURST = 64
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic [8*NUM_REQ-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [NUM_REQ-1:0]     req_last_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic [7:0]             in_data_o,
    output logic                   in_valid_o,
    input  logic                   in_ready_i,
    output logic                   busy_o
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [NUM_REQ-1:0] GNT_ONE = 1;

    typedef enum logic {ST_IDLE, ST_LOCKED} state_e;

    state_e               state_q;
    logic [IW-1:0]        owner_q;
    logic [IW-1:0]        ptr_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic [CW-1:0]        cnt_q;
    logic [7:0]           data_q;
    logic                 valid_q;

    logic                 slot_free;
    logic                 accept;
    logic                 pkt_end;
    logic [7:0]           sel_data;
    logic [IW-1:0]        ptr_d;
    logic [IW-1:0]        win_d;
    logic                 win_found;
    logic [IW:0]          arb_sum;

    // The slot can take a new byte when empty or when it drains this cycle.
    assign slot_free = !valid_q || in_ready_i;
    assign accept    = (state_q == ST_LOCKED) && req_valid_i[owner_q] && slot_free;
    assign sel_data  = req_data_i[{owner_q, 3'b000} +: 8];
    assign pkt_end   = accept && (req_last_i[owner_q] || (cnt_q == CW'(MAX_BURST - 1)));
    // The requester that just finished drops to lowest priority.
    assign ptr_d     = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);

    // Only the owner sees ready, and only while the slot can take a byte.
    always_comb begin
        req_ready_o = '0;
        if (state_q == ST_LOCKED) begin
            req_ready_o[owner_q] = slot_free;
        end
    end

    // Round-robin search from ptr_q; descending loop so the nearest valid index wins.
    always_comb begin
        win_found = 1'b0;
        win_d     = '0;
        arb_sum   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            arb_sum = {1'b0, ptr_q} + (IW+1)'(i);
            if (arb_sum >= (IW+1)'(NUM_REQ)) begin
                arb_sum = arb_sum - (IW+1)'(NUM_REQ);
            end
            if (req_valid_i[arb_sum[IW-1:0]]) begin
                win_found = 1'b1;
                win_d     = arb_sum[IW-1:0];
            end
        end
    end

    // Arbitration FSM, burst counter and output slot; a reset discards the pending byte.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (win_found) begin
                        owner_q <= win_d;
                        grant_q <= GNT_ONE << win_d;
                        cnt_q   <= '0;
                        state_q <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (accept) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                    // Leave without waiting for the slot to drain.
                    if (pkt_end) begin
                        state_q <= ST_IDLE;
                        grant_q <= '0;
                        ptr_q   <= ptr_d;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            if (accept) begin
                data_q  <= sel_data;
                valid_q <= 1'b1;
            end else if (valid_q && in_ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign grant_o    = grant_q;
    assign in_data_o  = data_q;
    assign in_valid_o = valid_q;
    assign busy_o     = (state_q == ST_LOCKED) || valid_q;

endmodule
